// File: rtl/mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_ctrl : multicycle MIPS control FSM (fetch/decode/exec/mem/wb)     |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module mc_ctrl #(
  parameter int OP_WIDTH    = 6,
  parameter int FN_WIDTH    = 6,
  parameter int ALUOP_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [OP_WIDTH-1:0]    op,
  input  logic [FN_WIDTH-1:0]    funct,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic [1:0]             pc_src,
  output logic                   ir_write,
  output logic                   iord,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   reg_write,
  output logic [1:0]             reg_dst,
  output logic [1:0]             wd_sel,
  output logic                   alu_srca,
  output logic [1:0]             alu_srcb,
  output logic                   ext_op,
  output logic [ALUOP_WIDTH-1:0] alu_op,
  output logic                   illegal_op,
  output logic [3:0]             state_o
);

  localparam logic [OP_WIDTH-1:0] c_OP_RTYPE = OP_WIDTH'('h00);
  localparam logic [OP_WIDTH-1:0] c_OP_J     = OP_WIDTH'('h02);
  localparam logic [OP_WIDTH-1:0] c_OP_BEQ   = OP_WIDTH'('h04);
  localparam logic [OP_WIDTH-1:0] c_OP_BNE   = OP_WIDTH'('h05);
  localparam logic [OP_WIDTH-1:0] c_OP_ADDI  = OP_WIDTH'('h08);
  localparam logic [OP_WIDTH-1:0] c_OP_ORI   = OP_WIDTH'('h0D);
  localparam logic [OP_WIDTH-1:0] c_OP_LUI   = OP_WIDTH'('h0F);
  localparam logic [OP_WIDTH-1:0] c_OP_LW    = OP_WIDTH'('h23);
  localparam logic [OP_WIDTH-1:0] c_OP_SW    = OP_WIDTH'('h2B);

  localparam logic [FN_WIDTH-1:0] c_FN_ADD = FN_WIDTH'('h20);
  localparam logic [FN_WIDTH-1:0] c_FN_SUB = FN_WIDTH'('h22);
  localparam logic [FN_WIDTH-1:0] c_FN_AND = FN_WIDTH'('h24);
  localparam logic [FN_WIDTH-1:0] c_FN_OR  = FN_WIDTH'('h25);
  localparam logic [FN_WIDTH-1:0] c_FN_SLT = FN_WIDTH'('h2A);

  // Shared ALUOp encodings consumed by the ALU.
  localparam logic [ALUOP_WIDTH-1:0] c_ALU_NOP = ALUOP_WIDTH'(0);
  localparam logic [ALUOP_WIDTH-1:0] c_ALU_ADD = ALUOP_WIDTH'(1);
  localparam logic [ALUOP_WIDTH-1:0] c_ALU_SUB = ALUOP_WIDTH'(2);
  localparam logic [ALUOP_WIDTH-1:0] c_ALU_AND = ALUOP_WIDTH'(3);
  localparam logic [ALUOP_WIDTH-1:0] c_ALU_OR  = ALUOP_WIDTH'(4);
  localparam logic [ALUOP_WIDTH-1:0] c_ALU_SLT = ALUOP_WIDTH'(5);
  localparam logic [ALUOP_WIDTH-1:0] c_ALU_LUI = ALUOP_WIDTH'(6);
  localparam logic [ALUOP_WIDTH-1:0] c_ALU_EQL = ALUOP_WIDTH'(7);
  localparam logic [ALUOP_WIDTH-1:0] c_ALU_BNE = ALUOP_WIDTH'(8);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

  // Outputs are forced idle while rstn is low so an abandoned access stops at once.
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    wd_sel     = 2'b00;
    alu_srca   = 1'b0;
    alu_srcb   = 2'b00;
    ext_op     = 1'b0;
    alu_op     = c_ALU_NOP;
    illegal_op = 1'b0;
    if (rstn) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          alu_srcb = 2'b01;
          alu_op   = c_ALU_ADD;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_srcb = 2'b11;
          ext_op   = 1'b1;
          alu_op   = c_ALU_ADD;
          case (op)
            c_OP_RTYPE:                   state_d = S_EXEC_R;
            c_OP_LW, c_OP_SW:             state_d = S_MEM_ADDR;
            c_OP_ADDI, c_OP_ORI, c_OP_LUI: state_d = S_EXEC_I;
            c_OP_BEQ, c_OP_BNE:           state_d = S_BRANCH;
            c_OP_J:                       state_d = S_JUMP;
            default: begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
        S_EXEC_R: begin
          alu_srca = 1'b1;
          state_d  = S_ALU_WB;
          case (funct)
            c_FN_ADD: alu_op = c_ALU_ADD;
            c_FN_SUB: alu_op = c_ALU_SUB;
            c_FN_AND: alu_op = c_ALU_AND;
            c_FN_OR:  alu_op = c_ALU_OR;
            c_FN_SLT: alu_op = c_ALU_SLT;
            default: begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
        S_EXEC_I: begin
          alu_srca = 1'b1;
          alu_srcb = 2'b10;
          state_d  = S_ALU_WB;
          case (op)
            c_OP_ORI: alu_op = c_ALU_OR;
            c_OP_LUI: alu_op = c_ALU_LUI;
            default: begin
              ext_op = 1'b1;
              alu_op = c_ALU_ADD;
            end
          endcase
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = (op == c_OP_RTYPE) ? 2'b01 : 2'b00;
          state_d   = S_FETCH;
        end
        S_MEM_ADDR: begin
          alu_srca = 1'b1;
          alu_srcb = 2'b10;
          ext_op   = 1'b1;
          alu_op   = c_ALU_ADD;
          state_d  = (op == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) state_d = S_MEM_WB;
        end
        S_MEM_WB: begin
          reg_write = 1'b1;
          wd_sel    = 2'b01;
          state_d   = S_FETCH;
        end
        S_MEM_WR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
          if (mem_ready) state_d = S_FETCH;
        end
        S_BRANCH: begin
          alu_srca = 1'b1;
          alu_op   = (op == c_OP_BNE) ? c_ALU_BNE : c_ALU_EQL;
          pc_src   = 2'b01;
          pc_write = zero;
          state_d  = S_FETCH;
        end
        S_JUMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mc_ctrl : directed self-checking bench for mc_ctrl                |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module tb_mc_ctrl;

  logic       clk;
  logic       rstn;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] wd_sel;
  logic       alu_srca;
  logic [1:0] alu_srcb;
  logic       ext_op;
  logic [4:0] alu_op;
  logic       illegal_op;
  logic [3:0] state_o;

  int n_cmp  = 0;
  int n_fail = 0;

  mc_ctrl #(.OP_WIDTH(6), .FN_WIDTH(6), .ALUOP_WIDTH(5)) dut (
    .clk(clk), .rstn(rstn), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .wd_sel(wd_sel), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .ext_op(ext_op), .alu_op(alu_op), .illegal_op(illegal_op),
    .state_o(state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b1; mem_ready = 1'b1; op = 6'h00; funct = 6'h20; zero = 1'b0;
    #1 rstn = 1'b0;
    #3;
    n_cmp++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", state_o); end
    n_cmp++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL rst_mem_read: got %0b want 0", mem_read); end
    n_cmp++; if (alu_op !== 5'd0) begin n_fail++; $display("FAIL rst_alu_op: got %0d want 0", alu_op); end
    n_cmp++; if (ir_write !== 1'b0) begin n_fail++; $display("FAIL rst_ir_write: got %0b want 0", ir_write); end
    n_cmp++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL rst_pc_write: got %0b want 0", pc_write); end
    n_cmp++; if (alu_srcb !== 2'd0) begin n_fail++; $display("FAIL rst_alu_srcb: got %0d want 0", alu_srcb); end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_cmp++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL fetch_state: got %0d want 0", state_o); end
    n_cmp++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL fetch_mem_read: got %0b want 1", mem_read); end
    n_cmp++; if (ir_write !== 1'b1) begin n_fail++; $display("FAIL fetch_ir_write: got %0b want 1", ir_write); end
    n_cmp++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL fetch_pc_write: got %0b want 1", pc_write); end
    n_cmp++; if (pc_src !== 2'd0) begin n_fail++; $display("FAIL fetch_pc_src: got %0d want 0", pc_src); end
    n_cmp++; if (iord !== 1'b0) begin n_fail++; $display("FAIL fetch_iord: got %0b want 0", iord); end
    n_cmp++; if (alu_srcb !== 2'd1) begin n_fail++; $display("FAIL fetch_alu_srcb: got %0d want 1", alu_srcb); end
    n_cmp++; if (alu_op !== 5'd1) begin n_fail++; $display("FAIL fetch_alu_op: got %0d want 1", alu_op); end
  endtask

  task automatic test_rtype();
    logic [5:0] fn [5];
    logic [4:0] ex [5];
    fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    ex = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
    op = 6'h00;
    for (int i = 0; i < 5; i++) begin
      funct = fn[i];
      tick();
      n_cmp++; if (state_o !== 4'd1) begin n_fail++; $display("FAIL r%0d_decode_state: got %0d want 1", i, state_o); end
      n_cmp++; if (alu_srcb !== 2'd3) begin n_fail++; $display("FAIL r%0d_decode_srcb: got %0d want 3", i, alu_srcb); end
      tick();
      n_cmp++; if (state_o !== 4'd2) begin n_fail++; $display("FAIL r%0d_exec_state: got %0d want 2", i, state_o); end
      n_cmp++; if (alu_op !== ex[i]) begin n_fail++; $display("FAIL r%0d_exec_alu_op: got %0d want %0d", i, alu_op, ex[i]); end
      n_cmp++; if ({alu_srca, alu_srcb} !== 3'b100) begin n_fail++; $display("FAIL r%0d_exec_src: got %0b want 100", i, {alu_srca, alu_srcb}); end
      tick();
      n_cmp++; if (state_o !== 4'd4) begin n_fail++; $display("FAIL r%0d_wb_state: got %0d want 4", i, state_o); end
      n_cmp++; if (reg_write !== 1'b1) begin n_fail++; $display("FAIL r%0d_wb_reg_write: got %0b want 1", i, reg_write); end
      n_cmp++; if (reg_dst !== 2'd1) begin n_fail++; $display("FAIL r%0d_wb_reg_dst: got %0d want 1", i, reg_dst); end
      n_cmp++; if (wd_sel !== 2'd0) begin n_fail++; $display("FAIL r%0d_wb_wd_sel: got %0d want 0", i, wd_sel); end
      tick();
      n_cmp++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL r%0d_back_fetch: got %0d want 0", i, state_o); end
      n_cmp++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL r%0d_fetch_reg_write: got %0b want 0", i, reg_write); end
    end
  endtask

  task automatic test_lw_stall();
    op = 6'h23; mem_ready = 1'b0;
    #1;
    n_cmp++; if (ir_write !== 1'b0) begin n_fail++; $display("FAIL fstall_ir_write: got %0b want 0", ir_write); end
    n_cmp++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL fstall_pc_write: got %0b want 0", pc_write); end
    tick();
    n_cmp++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL fstall_hold: got %0d want 0", state_o); end
    mem_ready = 1'b1;
    tick();
    n_cmp++; if (state_o !== 4'd1) begin n_fail++; $display("FAIL lw_decode: got %0d want 1", state_o); end
    tick();
    n_cmp++; if (state_o !== 4'd5) begin n_fail++; $display("FAIL lw_addr_state: got %0d want 5", state_o); end
    n_cmp++; if ({ext_op, alu_srcb, alu_op} !== 8'b1_10_00001) begin n_fail++; $display("FAIL lw_addr_ctl: got %b want 11000001", {ext_op, alu_srcb, alu_op}); end
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      n_cmp++; if (state_o !== 4'd6) begin n_fail++; $display("FAIL lw_rd%0d_state: got %0d want 6", i, state_o); end
      n_cmp++; if ({iord, mem_read, mem_write} !== 3'b110) begin n_fail++; $display("FAIL lw_rd%0d_strobes: got %b want 110", i, {iord, mem_read, mem_write}); end
      n_cmp++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL lw_rd%0d_reg_write: got %0b want 0", i, reg_write); end
      tick();
    end
    n_cmp++; if (state_o !== 4'd7) begin n_fail++; $display("FAIL lw_wb_state: got %0d want 7", state_o); end
    n_cmp++; if ({reg_write, wd_sel, reg_dst} !== 5'b1_01_00) begin n_fail++; $display("FAIL lw_wb_ctl: got %b want 10100", {reg_write, wd_sel, reg_dst}); end
    tick();
    n_cmp++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL lw_back_fetch: got %0d want 0", state_o); end
  endtask

  task automatic test_branch();
    op = 6'h04; zero = 1'b1;
    tick(); tick();
    n_cmp++; if (state_o !== 4'd9) begin n_fail++; $display("FAIL beq_state: got %0d want 9", state_o); end
    n_cmp++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL beq_taken_pc_write: got %0b want 1", pc_write); end
    n_cmp++; if (pc_src !== 2'd1) begin n_fail++; $display("FAIL beq_pc_src: got %0d want 1", pc_src); end
    n_cmp++; if (alu_op !== 5'd7) begin n_fail++; $display("FAIL beq_alu_op: got %0d want 7", alu_op); end
    n_cmp++; if ({alu_srca, alu_srcb} !== 3'b100) begin n_fail++; $display("FAIL beq_src: got %b want 100", {alu_srca, alu_srcb}); end
    zero = 1'b0;
    #1;
    n_cmp++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken_pc_write: got %0b want 0", pc_write); end
    tick();
    n_cmp++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL beq_back_fetch: got %0d want 0", state_o); end
    op = 6'h05; zero = 1'b1;
    tick(); tick();
    n_cmp++; if (alu_op !== 5'd8) begin n_fail++; $display("FAIL bne_alu_op: got %0d want 8", alu_op); end
    n_cmp++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL bne_taken_pc_write: got %0b want 1", pc_write); end
    zero = 1'b0;
    #1;
    n_cmp++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL bne_not_taken_pc_write: got %0b want 0", pc_write); end
    tick();
    n_cmp++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL bne_back_fetch: got %0d want 0", state_o); end
  endtask

  task automatic test_itype();
    logic [5:0] ops [3];
    logic [4:0] ex  [3];
    logic       ext [3];
    ops = '{6'h0D, 6'h0F, 6'h08};
    ex  = '{5'd4, 5'd6, 5'd1};
    ext = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      op = ops[i];
      tick(); tick();
      n_cmp++; if (state_o !== 4'd3) begin n_fail++; $display("FAIL i%0d_exec_state: got %0d want 3", i, state_o); end
      n_cmp++; if ({alu_srca, alu_srcb} !== 3'b110) begin n_fail++; $display("FAIL i%0d_exec_src: got %b want 110", i, {alu_srca, alu_srcb}); end
      n_cmp++; if (ext_op !== ext[i]) begin n_fail++; $display("FAIL i%0d_ext_op: got %0b want %0b", i, ext_op, ext[i]); end
      n_cmp++; if (alu_op !== ex[i]) begin n_fail++; $display("FAIL i%0d_alu_op: got %0d want %0d", i, alu_op, ex[i]); end
      tick();
      n_cmp++; if ({reg_write, reg_dst} !== 3'b100) begin n_fail++; $display("FAIL i%0d_wb_ctl: got %b want 100", i, {reg_write, reg_dst}); end
      tick();
      n_cmp++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL i%0d_back_fetch: got %0d want 0", i, state_o); end
    end
  endtask

  task automatic test_jump();
    op = 6'h02;
    tick(); tick();
    n_cmp++; if (state_o !== 4'd10) begin n_fail++; $display("FAIL j_state: got %0d want 10", state_o); end
    n_cmp++; if ({pc_write, pc_src} !== 3'b110) begin n_fail++; $display("FAIL j_pc_ctl: got %b want 110", {pc_write, pc_src}); end
    n_cmp++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL j_reg_write: got %0b want 0", reg_write); end
    tick();
    n_cmp++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL j_back_fetch: got %0d want 0", state_o); end
  endtask

  task automatic test_illegal();
    op = 6'h3F;
    tick();
    n_cmp++; if (state_o !== 4'd1) begin n_fail++; $display("FAIL ill_decode_state: got %0d want 1", state_o); end
    n_cmp++; if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL ill_pulse: got %0b want 1", illegal_op); end
    n_cmp++; if ({reg_write, mem_write, pc_write} !== 3'b000) begin n_fail++; $display("FAIL ill_no_writes: got %b want 000", {reg_write, mem_write, pc_write}); end
    tick();
    n_cmp++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL ill_next_fetch: got %0d want 0", state_o); end
    n_cmp++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL ill_pulse_end: got %0b want 0", illegal_op); end
    op = 6'h00; funct = 6'h00;
    tick(); tick();
    n_cmp++; if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL badfn_pulse: got %0b want 1", illegal_op); end
    tick();
    n_cmp++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL badfn_next_fetch: got %0d want 0", state_o); end
  endtask

  task automatic test_sw_reset();
    op = 6'h2B; mem_ready = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (state_o !== 4'd8) begin n_fail++; $display("FAIL sw_state: got %0d want 8", state_o); end
    n_cmp++; if ({iord, mem_read, mem_write} !== 3'b101) begin n_fail++; $display("FAIL sw_strobes: got %b want 101", {iord, mem_read, mem_write}); end
    tick();
    n_cmp++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL sw_back_fetch: got %0d want 0", state_o); end
    n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL sw_write_drop: got %0b want 0", mem_write); end
    tick(); tick();
    mem_ready = 1'b0;
    tick(); tick();
    n_cmp++; if ({state_o, mem_write} !== 5'b1000_1) begin n_fail++; $display("FAIL swst_hold: got %b want 10001", {state_o, mem_write}); end
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL swrst_mem_write: got %0b want 0", mem_write); end
    n_cmp++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL swrst_state: got %0d want 0", state_o); end
    n_cmp++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL swrst_reg_write: got %0b want 0", reg_write); end
    @(negedge clk);
    rstn = 1'b1; mem_ready = 1'b1;
    #1;
    n_cmp++; if ({state_o, mem_read, mem_write} !== 6'b0000_10) begin n_fail++; $display("FAIL swrst_resume: got %b want 000010", {state_o, mem_read, mem_write}); end
    tick();
    n_cmp++; if (state_o !== 4'd1) begin n_fail++; $display("FAIL swrst_decode: got %0d want 1", state_o); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch();
    test_itype();
    test_jump();
    test_illegal();
    test_sw_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
